fifo_word_packer: RTL

- Read-side consumer of the async byte FIFO; runs entirely in the FIFO read clock domain.
- Pops bytes with `dequeue`, accounting for the FIFO's 1-cycle registered read latency.
- Packs PACK consecutive bytes into one wide word, first byte in the LSBs.
- Presents each word downstream on a valid/ready handshake with full backpressure.

---
 rtl/fifo_word_packer.sv | 112 +++++++++++
 1 files changed

// File: rtl/fifo_word_packer.sv
// Read-side consumer of the async byte FIFO: pops bytes and packs PACK of them (first byte in the LSBs)
// into one word on a valid/ready output. Optional macro PACKER_FLUSH_EN adds flush/out_cnt for partial words.
module fifo_word_packer #(
    parameter int DATA_WIDTH = 8,
    parameter int PACK       = 4
) (
    input  logic                         clk_read,
    input  logic                         rst,
    input  logic                         fifo_empty,
    input  logic [DATA_WIDTH-1:0]        fifo_data,
    output logic                         dequeue,
    output logic [DATA_WIDTH*PACK-1:0]   out_data,
    output logic                         out_valid,
    input  logic                         out_ready
`ifdef PACKER_FLUSH_EN
    ,
    input  logic                         flush,
    output logic [$clog2(PACK+1)-1:0]    out_cnt
`endif
);

    localparam int CW = $clog2(PACK + 1);
    localparam int WW = DATA_WIDTH * PACK;
    localparam logic [CW-1:0] PACK_C = CW'(PACK);
    localparam logic [CW:0]   PACK_S = (CW + 1)'(PACK);

    logic [CW-1:0]   asm_cnt_reg;
    logic            inflight_reg;
    logic [WW-1:0]   asm_reg;
    logic [WW-1:0]   out_data_reg;
    logic            out_valid_reg;

    logic [CW:0]     pend_sum;
    logic [CW-1:0]   cnt_next;
    logic [WW-1:0]   asm_next;
    logic [PACK-1:0] lane_hit;
    logic            flush_req;
    logic            out_free;
    logic            word_done;
    logic            load_full;
    logic            load_part;
    logic            load_word;

`ifdef PACKER_FLUSH_EN
    assign flush_req = flush;
`else
    assign flush_req = 1'b0;
`endif

    // Bytes already committed to the assembly register, counting the one still on the FIFO read port.
    assign pend_sum = {1'b0, asm_cnt_reg} + {{CW{1'b0}}, inflight_reg};
    assign dequeue  = !rst && !fifo_empty && !flush_req && (pend_sum < PACK_S);

    genvar gi;
    generate
        for (gi = 0; gi < PACK; gi++) begin : g_lane
            assign lane_hit[gi] = inflight_reg && (asm_cnt_reg == CW'(gi));
            assign asm_next[gi*DATA_WIDTH +: DATA_WIDTH] =
                lane_hit[gi] ? fifo_data : asm_reg[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    assign cnt_next  = asm_cnt_reg + {{(CW-1){1'b0}}, inflight_reg};
    assign out_free  = !out_valid_reg || out_ready;
    assign word_done = (cnt_next == PACK_C);
    assign load_full = word_done && out_free;
    // A partial word only goes out once the read port is quiet, so no byte can land after it.
    assign load_part = flush_req && !inflight_reg && (asm_cnt_reg != '0) && !word_done && out_free;
    assign load_word = load_full || load_part;

    always_ff @(posedge clk_read) begin
        if (rst) begin
            asm_cnt_reg   <= '0;
            inflight_reg  <= 1'b0;
            asm_reg       <= '0;
            out_data_reg  <= '0;
            out_valid_reg <= 1'b0;
        end else begin
            inflight_reg <= dequeue;
            if (load_word) begin
                out_data_reg  <= asm_next;
                out_valid_reg <= 1'b1;
                asm_reg       <= '0;
                asm_cnt_reg   <= '0;
            end else begin
                asm_reg     <= asm_next;
                asm_cnt_reg <= cnt_next;
                if (out_valid_reg && out_ready) begin
                    out_valid_reg <= 1'b0;
                end
            end
        end
    end

    assign out_data  = out_data_reg;
    assign out_valid = out_valid_reg;

`ifdef PACKER_FLUSH_EN
    logic [CW-1:0] out_cnt_reg;

    always_ff @(posedge clk_read) begin
        if (rst) begin
            out_cnt_reg <= '0;
        end else if (load_word) begin
            out_cnt_reg <= cnt_next;
        end
    end

    assign out_cnt = out_cnt_reg;
`endif

endmodule
